// File: rtl/reg_lock_retention_ctrl.sv
// Bank of lockable configuration registers with sticky lock bits that survive
// sleep isolation and the sequential restore walk; only rst_i clears a lock.
module reg_lock_retention_ctrl #(
  parameter  int NUM_REGS = 6,
  parameter  int DATA_W   = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [AW-1:0]              wr_addr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       lock_en_i,
  input  logic [AW-1:0]              lock_addr_i,
  input  logic                       sleep_req_i,
  input  logic                       wake_req_i,
  output logic                       wr_ack_o,
  output logic                       wr_err_o,
  output logic                       busy_o,
  output logic [1:0]                 state_o,
  output logic [NUM_REGS*DATA_W-1:0] reg_data_o,
  output logic [NUM_REGS-1:0]        reg_lck_o
);

  localparam int            IW   = $clog2(NUM_REGS + 1);
  localparam logic [AW:0]   NR_W = (AW+1)'(NUM_REGS);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SLEEP   = 2'b01,
    ST_RESTORE = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]   ret_q [NUM_REGS];
  logic [NUM_REGS-1:0] lck_q;
  logic                wr_ack_q, wr_err_q;
  logic                wr_accept, wr_reject, lock_set;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (sleep_req_i) state_d = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (wake_req_i) begin
          state_d = ST_RESTORE;
          idx_d   = '0;
        end
      end
      ST_RESTORE: begin
        // Last register becomes visible exactly as the bank returns to IDLE.
        if (idx_q == LAST) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // The lock check uses the pre-edge lock value, so a same-cycle write+lock lands the data.
  always_comb begin
    wr_accept = wr_en_i && (state_q == ST_IDLE) && ({1'b0, wr_addr_i} < NR_W)
                && !lck_q[wr_addr_i];
    wr_reject = wr_en_i && !wr_accept;
    lock_set  = lock_en_i && (state_q == ST_IDLE) && ({1'b0, lock_addr_i} < NR_W);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      lck_q    <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) ret_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ack_q <= wr_accept;
      wr_err_q <= wr_reject;
      if (wr_accept) ret_q[wr_addr_i] <= wr_data_i;
      if (lock_set)  lck_q[lock_addr_i] <= 1'b1;
    end
  end

  always_comb begin
    reg_data_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((state_q == ST_IDLE) || ((state_q == ST_RESTORE) && (IW'(i) < idx_q)))
        reg_data_o[i*DATA_W +: DATA_W] = ret_q[i];
    end
  end

  assign wr_ack_o  = wr_ack_q;
  assign wr_err_o  = wr_err_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign state_o   = state_q;
  assign reg_lck_o = lck_q;

endmodule

// File: tb/tb_reg_lock_retention_ctrl.sv
// Directed vector table for the documented scenarios, then randomized traffic
// compared against a visibility-count reference model.
module tb_reg_lock_retention_ctrl;
  localparam int NUM = 6;
  localparam int DW  = 32;
  localparam int AW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, we, le, sl, wk;
  logic [AW-1:0]     wa, la;
  logic [DW-1:0]     wd;
  logic              ack, err, busy;
  logic [1:0]        st;
  logic [NUM*DW-1:0] data;
  logic [NUM-1:0]    lck;

  int errors = 0;
  int checks = 0;

  reg_lock_retention_ctrl #(.NUM_REGS(NUM), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(we), .wr_addr_i(wa), .wr_data_i(wd),
    .lock_en_i(le), .lock_addr_i(la), .sleep_req_i(sl), .wake_req_i(wk),
    .wr_ack_o(ack), .wr_err_o(err), .busy_o(busy), .state_o(st),
    .reg_data_o(data), .reg_lck_o(lck)
  );

  typedef struct {
    logic          rst, we, le, sl, wk;
    logic [AW-1:0] wa, la;
    logic [DW-1:0] wd;
    logic          e_ack, e_err;
    logic [1:0]    e_st;
    logic [NUM-1:0] e_lck;
    int            c_idx;
    logic [DW-1:0] c_val;
  } vec_t;

  vec_t tbl[$];

  // Reference model: state as 0/1/2, m_vis = how many low-index registers are visible.
  logic [DW-1:0]  m_ret [NUM];
  logic [NUM-1:0] m_lck;
  int             m_st, m_vis;
  logic           m_ack, m_err;

  function automatic vec_t mk(logic r, logic w, int a, logic [DW-1:0] d, logic l, int la_i,
                              logic s, logic k, logic ea, logic ee, int es, logic [NUM-1:0] el,
                              int ci, logic [DW-1:0] cv);
    vec_t v;
    v.rst = r; v.we = w; v.wa = AW'(a); v.wd = d; v.le = l; v.la = AW'(la_i);
    v.sl = s; v.wk = k; v.e_ack = ea; v.e_err = ee; v.e_st = 2'(es); v.e_lck = el;
    v.c_idx = ci; v.c_val = cv;
    return v;
  endfunction

  task automatic model_step();
    bit ok;
    if (rst) begin
      for (int i = 0; i < NUM; i++) m_ret[i] = '0;
      m_lck = '0; m_st = 0; m_vis = NUM; m_ack = 0; m_err = 0;
    end else begin
      ok = we && (m_st == 0) && (int'(wa) < NUM) && !m_lck[wa];
      m_ack = ok;
      m_err = we && !ok;
      if (ok) m_ret[wa] = wd;
      if (le && (m_st == 0) && (int'(la) < NUM)) m_lck[la] = 1'b1;
      case (m_st)
        0: if (sl) begin m_st = 1; m_vis = 0; end
        1: if (wk) begin m_st = 2; m_vis = 0; end
        default: begin
          m_vis++;
          if (m_vis == NUM) m_st = 0;
        end
      endcase
    end
  endtask

  task automatic chk(string name, logic [NUM*DW-1:0] act, logic [NUM*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  logic [NUM*DW-1:0] exp_data;

  initial begin
    rst = 1; we = 0; wa = '0; wd = '0; le = 0; la = '0; sl = 0; wk = 0;
    for (int i = 0; i < NUM; i++) m_ret[i] = '0;
    m_lck = '0; m_st = 0; m_vis = NUM; m_ack = 0; m_err = 0;
    //        rst we a  data          le la sl wk  ack err st lck    chk val
    tbl.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 6'h00, 2, 32'h0));
    tbl.push_back(mk(0, 1, 2, 32'hDEADBEEF, 0, 0, 0, 0,  1, 0, 0, 6'h00, 2, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 4, 32'hFFFFFFFF, 0, 4, 0, 0,  0, 0, 0, 6'h00, 4, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 2, 0, 0,  0, 0, 0, 6'h04, 2, 32'hDEADBEEF));
    tbl.push_back(mk(0, 1, 2, 32'h12345678, 0, 0, 0, 0,  0, 1, 0, 6'h04, 2, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 0,  0, 0, 1, 6'h04, 2, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h11111111, 1, 0, 0, 0,  0, 1, 1, 6'h04, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 1,  0, 0, 2, 6'h04, 2, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 0,  0, 0, 2, 6'h04, 2, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 1,  0, 0, 2, 6'h04, 2, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h04, 2, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h04, 2, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h04, 2, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 6'h04, 2, 32'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 1, 0,  0, 0, 1, 6'h04, 2, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 1,  0, 0, 2, 6'h04, 2, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h04, 2, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h04, 2, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h04, 2, 32'hDEADBEEF));
    tbl.push_back(mk(1, 1, 2, 32'h0,        1, 0, 1, 1,  0, 0, 0, 6'h00, 2, 32'h0));
    tbl.push_back(mk(0, 1, 5, 32'hA5A5A5A5, 1, 5, 0, 0,  1, 0, 0, 6'h20, 5, 32'hA5A5A5A5));
    tbl.push_back(mk(0, 1, 5, 32'h0,        0, 0, 0, 0,  0, 1, 0, 6'h20, 5, 32'hA5A5A5A5));
    tbl.push_back(mk(0, 1, 1, 32'h0BADF00D, 0, 0, 1, 0,  1, 0, 1, 6'h20, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 1,  0, 0, 2, 6'h20, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h20, 1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h20, 1, 32'h0BADF00D));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h20, 5, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h20, 5, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 2, 6'h20, 5, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 0,  0, 0, 0, 6'h20, 5, 32'hA5A5A5A5));

    for (int n = 0; n < tbl.size(); n++) begin
      rst = tbl[n].rst; we = tbl[n].we; wa = tbl[n].wa; wd = tbl[n].wd;
      le = tbl[n].le; la = tbl[n].la; sl = tbl[n].sl; wk = tbl[n].wk;
      cycle();
      chk($sformatf("vec%0d ack", n), NUM*DW'(ack), NUM*DW'(tbl[n].e_ack));
      chk($sformatf("vec%0d err", n), NUM*DW'(err), NUM*DW'(tbl[n].e_err));
      chk($sformatf("vec%0d state", n), NUM*DW'(st), NUM*DW'(tbl[n].e_st));
      chk($sformatf("vec%0d busy", n), NUM*DW'(busy), NUM*DW'(tbl[n].e_st != 2'b00));
      chk($sformatf("vec%0d lck", n), NUM*DW'(lck), NUM*DW'(tbl[n].e_lck));
      chk($sformatf("vec%0d reg%0d", n, tbl[n].c_idx), NUM*DW'(data[tbl[n].c_idx*DW +: DW]),
          NUM*DW'(tbl[n].c_val));
    end

    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      we  = $urandom_range(0, 1);
      wa  = AW'($urandom_range(0, 7));
      wd  = $urandom;
      le  = ($urandom_range(0, 9) == 0);
      la  = AW'($urandom_range(0, 7));
      sl  = ($urandom_range(0, 9) == 0);
      wk  = ($urandom_range(0, 3) == 0);
      cycle();
      exp_data = '0;
      for (int i = 0; i < NUM; i++)
        if (i < m_vis) exp_data[i*DW +: DW] = m_ret[i];
      chk("rnd ack", NUM*DW'(ack), NUM*DW'(m_ack));
      chk("rnd err", NUM*DW'(err), NUM*DW'(m_err));
      chk("rnd state", NUM*DW'(st), NUM*DW'(m_st));
      chk("rnd busy", NUM*DW'(busy), NUM*DW'(m_st != 0));
      chk("rnd lck", NUM*DW'(lck), NUM*DW'(m_lck));
      chk("rnd data", data, exp_data);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
